x25519_apb_requester: RTL and testbench

APB requester that drives the Curve25519 accelerator's APB completer to run one `crypto_scalarmult` end to end. It loads scalar `e` and input point `work`, issues the command, polls status until idle, then reads back the 256-bit result. It sits between a local datapath (e.g. a handshake engine) and the APB segment carrying the accelerator, with no CPU involved.

---
 rtl/x25519_apb_requester_pkg.sv | 37 +++
 rtl/x25519_apb_requester_if.sv | 28 ++
 rtl/x25519_apb_requester_xfer.sv | 51 +++++
 rtl/x25519_apb_requester.sv | 182 ++++++++++++++++++
 tb/tb_x25519_apb_requester.sv | 293 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/x25519_apb_requester_pkg.sv
// Curve25519 accelerator register map and requester op numbering.
// Shared with the accelerator's APB completer.
package Curve25519Registers;

   localparam int unsigned APB_DATA_WIDTH = 32;

   localparam logic [11:0] E_OFFSET        = 12'h000;
   localparam logic [11:0] STATUS_OFFSET   = 12'h020;
   localparam logic [11:0] CMD_OFFSET      = 12'h028;
   localparam logic [11:0] WORK_OFFSET     = 12'h060;
   localparam logic [11:0] DATA_OUT_OFFSET = 12'h140;

   localparam logic [31:0] CMD_CRYPTO_SCALARMULT = 32'h0000_0001;

   localparam logic [4:0] OP_E_LAST    = 5'd7;
   localparam logic [4:0] OP_WORK_LAST = 5'd15;
   localparam logic [4:0] OP_CMD       = 5'd16;
   localparam logic [4:0] OP_POLL      = 5'd17;
   localparam logic [4:0] OP_READ0     = 5'd18;
   localparam logic [4:0] OP_LAST      = 5'd25;

   function automatic logic [11:0] op_offset(input logic [4:0] op);
      logic [4:0] rd;
      rd = op - OP_READ0;
      if (op <= OP_E_LAST)
         return E_OFFSET + 12'({op[2:0], 2'b00});
      else if (op <= OP_WORK_LAST)
         return WORK_OFFSET + 12'({op[2:0], 2'b00});
      else if (op == OP_CMD)
         return CMD_OFFSET;
      else if (op == OP_POLL)
         return STATUS_OFFSET;
      else
         return DATA_OUT_OFFSET + 12'({rd[2:0], 2'b00});
   endfunction

endpackage

// File: rtl/x25519_apb_requester_if.sv
// APB segment between the requester and the Curve25519 accelerator completer.
interface APB #(
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned DATA_WIDTH = 32
) (
   input logic pclk
);
   logic [ADDR_WIDTH-1:0]   paddr;
   logic                    psel;
   logic                    penable;
   logic                    pwrite;
   logic [DATA_WIDTH-1:0]   pwdata;
   logic [DATA_WIDTH/8-1:0] pstrb;
   logic [2:0]              pprot;
   logic [DATA_WIDTH-1:0]   prdata;
   logic                    pready;
   logic                    pslverr;

   modport requester (
      output paddr, psel, penable, pwrite, pwdata, pstrb, pprot,
      input  prdata, pready, pslverr
   );

   modport completer (
      input  pclk, paddr, psel, penable, pwrite, pwdata, pstrb, pprot,
      output prdata, pready, pslverr
   );
endinterface

// File: rtl/x25519_apb_requester_xfer.sv
// Single APB transfer engine: req (one cycle, SETUP phase) starts a transfer,
// complete pulses in the ACCESS cycle that sees pready.
module x25519_apb_xfer (
   input  logic        pclk,
   input  logic        preset_n,
   APB.requester       apb,
   input  logic        req,
   input  logic [31:0] addr,
   input  logic        write,
   input  logic [31:0] wdata,
   output logic        complete,
   output logic        slverr,
   output logic [31:0] rdata
);

   logic        in_access;
   logic [31:0] addr_q;
   logic [31:0] wdata_q;
   logic        write_q;

   always_ff @(posedge pclk) begin
      if (!preset_n) begin
         in_access <= 1'b0;
         addr_q    <= '0;
         wdata_q   <= '0;
         write_q   <= 1'b0;
      end else if (req) begin
         in_access <= 1'b1;
         addr_q    <= addr;
         wdata_q   <= wdata;
         write_q   <= write;
      end else if (complete) begin
         in_access <= 1'b0;
      end
   end

   // Setup phase drives the request fields directly; access phase replays the
   // captured copy so the bus stays stable however long pready is held off.
   assign apb.psel    = req | in_access;
   assign apb.penable = in_access;
   assign apb.paddr   = req ? addr  : addr_q;
   assign apb.pwrite  = req ? write : write_q;
   assign apb.pwdata  = req ? wdata : wdata_q;
   assign apb.pstrb   = 4'hF;
   assign apb.pprot   = 3'b000;

   assign complete = in_access & apb.pready;
   assign slverr   = complete & apb.pslverr;
   assign rdata    = apb.prdata;

endmodule

// File: rtl/x25519_apb_requester.sv
// Runs one crypto_scalarmult on the Curve25519 accelerator over APB.
// Optional poll timeout: define X25519_REQ_TIMEOUT_EN.
//
//   state    | meaning
//   S_IDLE   | waiting for start, inputs captured on accept
//   S_SETUP  | APB setup phase for the current op
//   S_ACCESS | APB access phase, waiting for pready
//   S_GAP    | idle cycles between status polls
//   S_FINISH | done pulse issued next cycle; result published on success
module x25519_apb_requester
   import Curve25519Registers::*;
#(
   parameter logic [31:0] BASE_ADDR     = 32'h0,
   parameter int unsigned POLL_GAP      = 2,
   parameter int unsigned TIMEOUT_POLLS = 4096
) (
   input  logic         pclk,
   input  logic         preset_n,
   APB.requester        apb,
   input  logic         start,
   input  logic [255:0] e,
   input  logic [255:0] work_in,
   output logic         busy,
   output logic         done,
   output logic         err,
   output logic [255:0] work_out
);

   if ($bits(apb.pwdata) != APB_DATA_WIDTH || TIMEOUT_POLLS == 0 || TIMEOUT_POLLS > 65535) begin : g_param_check
      $error("x25519_apb_requester: APB must be 32 bits and TIMEOUT_POLLS in 1..65535");
   end

   localparam logic [15:0] GAP_LOAD = (POLL_GAP > 0) ? 16'(POLL_GAP - 1) : 16'd0;

   typedef enum logic [2:0] {S_IDLE, S_SETUP, S_ACCESS, S_GAP, S_FINISH} state_t;

   state_t       state, state_nxt;
   logic [4:0]   op, op_nxt, rd_idx;
   logic         abort, abort_nxt;
   logic [15:0]  gap_cnt, gap_nxt;
   logic         capture;
   logic [255:0] e_q, work_q, shadow;

   logic         req, complete, slverr;
   logic [31:0]  rdata, xfer_addr, xfer_wdata;
   logic         xfer_write;

`ifdef X25519_REQ_TIMEOUT_EN
   logic [15:0]  poll_cnt;
   logic         poll_limit;
   assign poll_limit = ({1'b0, poll_cnt} + 17'd1) >= 17'(TIMEOUT_POLLS);
`endif

   x25519_apb_xfer u_xfer (
      .pclk     (pclk),
      .preset_n (preset_n),
      .apb      (apb),
      .req      (req),
      .addr     (xfer_addr),
      .write    (xfer_write),
      .wdata    (xfer_wdata),
      .complete (complete),
      .slverr   (slverr),
      .rdata    (rdata)
   );

   assign rd_idx = op - OP_READ0;
   assign busy   = (state != S_IDLE);

   always_comb begin
      xfer_addr  = BASE_ADDR + {20'h0, op_offset(op)};
      xfer_write = (op <= OP_CMD);
      xfer_wdata = '0;
      if (op <= OP_E_LAST)
         xfer_wdata = e_q[{op[2:0], 5'd0} +: 32];
      else if (op <= OP_WORK_LAST)
         xfer_wdata = work_q[{op[2:0], 5'd0} +: 32];
      else if (op == OP_CMD)
         xfer_wdata = CMD_CRYPTO_SCALARMULT;
   end

   always_comb begin
      state_nxt = state;
      op_nxt    = op;
      abort_nxt = abort;
      gap_nxt   = gap_cnt;
      capture   = 1'b0;
      req       = 1'b0;
      case (state)
         S_IDLE: begin
            if (start) begin
               capture   = 1'b1;
               abort_nxt = 1'b0;
               op_nxt    = 5'd0;
               state_nxt = S_SETUP;
            end
         end
         S_SETUP: begin
            req       = 1'b1;
            state_nxt = S_ACCESS;
         end
         S_ACCESS: begin
            if (complete) begin
               if (slverr) begin
                  abort_nxt = 1'b1;
                  state_nxt = S_FINISH;
               end else if (op == OP_POLL && rdata[0]) begin
`ifdef X25519_REQ_TIMEOUT_EN
                  if (poll_limit) begin
                     abort_nxt = 1'b1;
                     state_nxt = S_FINISH;
                  end else
`endif
                  if (POLL_GAP == 0) begin
                     state_nxt = S_SETUP;
                  end else begin
                     gap_nxt   = GAP_LOAD;
                     state_nxt = S_GAP;
                  end
               end else if (op == OP_POLL) begin
                  op_nxt    = OP_READ0;
                  state_nxt = S_SETUP;
               end else if (op == OP_LAST) begin
                  state_nxt = S_FINISH;
               end else begin
                  op_nxt    = op + 5'd1;
                  state_nxt = S_SETUP;
               end
            end
         end
         S_GAP: begin
            if (gap_cnt == 16'd0)
               state_nxt = S_SETUP;
            else
               gap_nxt = gap_cnt - 16'd1;
         end
         S_FINISH: state_nxt = S_IDLE;
         default:  state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge pclk) begin
      if (!preset_n) begin
         state    <= S_IDLE;
         op       <= '0;
         abort    <= 1'b0;
         gap_cnt  <= '0;
         e_q      <= '0;
         work_q   <= '0;
         shadow   <= '0;
         done     <= 1'b0;
         err      <= 1'b0;
         work_out <= '0;
`ifdef X25519_REQ_TIMEOUT_EN
         poll_cnt <= '0;
`endif
      end else begin
         state   <= state_nxt;
         op      <= op_nxt;
         abort   <= abort_nxt;
         gap_cnt <= gap_nxt;
         done    <= (state == S_FINISH);
         err     <= (state == S_FINISH) && abort;
         if (capture) begin
            e_q    <= e;
            work_q <= work_in;
         end
         // Readback is staged so an aborted run never exposes a partial result.
         if (complete && !slverr && op >= OP_READ0)
            shadow[{rd_idx[2:0], 5'd0} +: 32] <= rdata;
         if (state == S_FINISH && !abort)
            work_out <= shadow;
`ifdef X25519_REQ_TIMEOUT_EN
         if (complete && op == OP_CMD)
            poll_cnt <= '0;
         else if (complete && op == OP_POLL)
            poll_cnt <= poll_cnt + 16'd1;
`endif
      end
   end

endmodule

// File: tb/tb_x25519_apb_requester.sv
// Directed + randomized bench: behavioural APB completer and expected-transfer list.
module tb_x25519_apb_requester;

   localparam logic [31:0] BASE = 32'h0000_2000;
   localparam int          GAP  = 2;
`ifdef X25519_REQ_TIMEOUT_EN
   localparam int          TPOLLS = 4;
`else
   localparam int          TPOLLS = 4096;
`endif
   localparam logic [255:0] RFC_ONE_ITER =
      256'h422c8e7a6227d7bca1350b3e2bb7279f7897b87bb6854b783c60e80311ae3079;

   logic         pclk = 1'b0;
   logic         preset_n = 1'b0;
   logic         start = 1'b0;
   logic [255:0] e = '0;
   logic [255:0] work_in = '0;
   logic         busy, done, err;
   logic [255:0] work_out;

   always #5 pclk = ~pclk;

   APB apb_bus (.pclk(pclk));

   x25519_apb_requester #(
      .BASE_ADDR     (BASE),
      .POLL_GAP      (GAP),
      .TIMEOUT_POLLS (TPOLLS)
   ) dut (
      .pclk     (pclk),
      .preset_n (preset_n),
      .apb      (apb_bus),
      .start    (start),
      .e        (e),
      .work_in  (work_in),
      .busy     (busy),
      .done     (done),
      .err      (err),
      .work_out (work_out)
   );

   // completer model
   int           wait_states = 0;
   logic [31:0]  err_addr = 32'hFFFF_FFFF;
   logic [255:0] result = '0;
   int           busy_polls = 0;
   int           polls_left = 0;
   bit           stuck = 0;
   int           wcnt = 0;
   logic [64:0]  log_q[$];
   logic [64:0]  exp_q[$];

   always_comb begin
      logic [31:0] off;
      off = apb_bus.paddr - BASE;
      apb_bus.pready  = apb_bus.psel && apb_bus.penable && (wcnt == wait_states);
      apb_bus.pslverr = apb_bus.pready && (apb_bus.paddr == err_addr);
      apb_bus.prdata  = 32'h0;
      if (apb_bus.psel && apb_bus.penable && !apb_bus.pwrite) begin
         if (off == 32'h20)
            apb_bus.prdata = {31'h0, (stuck || polls_left > 0)};
         else if (off >= 32'h140 && off < 32'h160)
            apb_bus.prdata = result[(off - 32'h140) * 8 +: 32];
      end
   end

   always @(posedge pclk) begin
      if (apb_bus.psel && apb_bus.penable) begin
         if (apb_bus.pready) begin
            wcnt <= 0;
            log_q.push_back({apb_bus.pwrite, apb_bus.paddr,
                             apb_bus.pwrite ? apb_bus.pwdata : apb_bus.prdata});
            if (apb_bus.pwrite && apb_bus.paddr == BASE + 32'h28 && apb_bus.pwdata == 32'h1)
               polls_left <= busy_polls;
            if (!apb_bus.pwrite && apb_bus.paddr == BASE + 32'h20 && polls_left > 0)
               polls_left <= polls_left - 1;
         end else begin
            wcnt <= wcnt + 1;
         end
      end
   end

   // output / protocol monitors
   int           done_cnt = 0, busy_cycles = 0, stab_bad = 0, sig_bad = 0;
   int           acc_len = 0, max_acc = 0, min_acc = 1000;
   logic         err_at_done = 1'b0;
   logic [255:0] out_at_done = '0;
   logic [31:0]  s_addr, s_data;
   logic         s_wr;

   always @(negedge pclk) begin
      if (busy) busy_cycles++;
      if (done) begin
         done_cnt++;
         err_at_done = err;
         out_at_done = work_out;
      end
      if (apb_bus.psel) begin
         if (apb_bus.pstrb != 4'hF || apb_bus.pprot != 3'b000) sig_bad++;
         if (!apb_bus.pwrite && apb_bus.pwdata != 32'h0) sig_bad++;
         if (!apb_bus.penable) begin
            s_addr = apb_bus.paddr; s_data = apb_bus.pwdata; s_wr = apb_bus.pwrite; acc_len = 0;
         end else begin
            acc_len++;
            if (apb_bus.paddr != s_addr || apb_bus.pwdata != s_data || apb_bus.pwrite != s_wr)
               stab_bad++;
            if (apb_bus.pready) begin
               if (acc_len > max_acc) max_acc = acc_len;
               if (acc_len < min_acc) min_acc = acc_len;
            end
         end
      end
   end

   int total = 0, bad = 0;

   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [255:0] rnd256();
      logic [255:0] r;
      for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
      return r;
   endfunction

   // Expected transfer list: writes of e and work, CMD, polls, result reads;
   // an abort keeps only the transfers up to and including the failing one.
   task automatic build_exp(input logic [255:0] ev, input logic [255:0] wv,
                            input logic [255:0] rv, input int nbusy, input int abort_at);
      exp_q.delete();
      for (int i = 0; i < 8; i++) exp_q.push_back({1'b1, BASE + 32'(4*i), ev[i*32 +: 32]});
      for (int i = 0; i < 8; i++) exp_q.push_back({1'b1, BASE + 32'h60 + 32'(4*i), wv[i*32 +: 32]});
      exp_q.push_back({1'b1, BASE + 32'h28, 32'h1});
      for (int p = 0; p < nbusy; p++) exp_q.push_back({1'b0, BASE + 32'h20, 32'h1});
      exp_q.push_back({1'b0, BASE + 32'h20, 32'h0});
      for (int i = 0; i < 8; i++) exp_q.push_back({1'b0, BASE + 32'h140 + 32'(4*i), rv[i*32 +: 32]});
      if (abort_at >= 0)
         while (exp_q.size() > abort_at + 1) void'(exp_q.pop_back());
   endtask

   task automatic cmp_log(input string tag);
      chk({tag, "_nxfer"}, 256'(log_q.size()), 256'(exp_q.size()));
      for (int i = 0; i < exp_q.size() && i < log_q.size(); i++)
         chk($sformatf("%s_xfer%0d", tag, i), log_q[i], exp_q[i]);
   endtask

   task automatic run(input logic [255:0] ev, input logic [255:0] wv, input int extra_start_at,
                      input int budget, output bit timed_out);
      int d0;
      d0 = done_cnt;
      log_q.delete();
      busy_cycles = 0; max_acc = 0; min_acc = 1000;
      @(negedge pclk);
      e = ev; work_in = wv; start = 1'b1;
      @(negedge pclk);
      start = 1'b0;
      timed_out = 1'b1;
      for (int c = 0; c < budget; c++) begin
         @(negedge pclk);
         #1;
         start = (c == extra_start_at);
         if (done_cnt != d0) begin
            timed_out = 1'b0;
            break;
         end
      end
      start = 1'b0;
   endtask

   initial begin
      bit           to;
      int           d0, nb;
      logic [255:0] ev, wv, prev;

      repeat (3) @(negedge pclk);
      chk("rst_bus", {apb_bus.psel, apb_bus.penable, apb_bus.pwrite, apb_bus.paddr, apb_bus.pwdata}, '0);
      chk("rst_flags", {busy, done, err}, '0);
      chk("rst_work_out", work_out, '0);
      preset_n = 1'b1;

      // RFC 7748 base point, zero-wait completer
      result = RFC_ONE_ITER; busy_polls = 3; wait_states = 0;
      build_exp(256'd9, 256'd9, result, 3, -1);
      d0 = done_cnt;
      run(256'd9, 256'd9, -1, 2000, to);
      chk("t1_timeout", to, 1'b0);
      cmp_log("t1");
      chk("t1_done_cnt", 256'(done_cnt - d0), 256'd1);
      chk("t1_err", err_at_done, 1'b0);
      chk("t1_work_out", out_at_done, RFC_ONE_ITER);
      chk("t1_busy_cycles", 256'(busy_cycles), 256'(34 + (3 + 1) * (2 + GAP) - GAP + 16 + 1));
      chk("t1_access_len", 256'(max_acc), 256'd1);

      // random operands, three wait states per transfer
      ev = rnd256(); wv = rnd256(); result = rnd256();
      nb = int'($urandom_range(0, 4)); busy_polls = nb; wait_states = 3;
      build_exp(ev, wv, result, nb, -1);
      d0 = done_cnt;
      run(ev, wv, -1, 3000, to);
      chk("t2_timeout", to, 1'b0);
      cmp_log("t2");
      chk("t2_done_cnt", 256'(done_cnt - d0), 256'd1);
      chk("t2_err", err_at_done, 1'b0);
      chk("t2_work_out", out_at_done, result);
      chk("t2_access_max", 256'(max_acc), 256'd4);
      chk("t2_access_min", 256'(min_acc), 256'd4);
      wait_states = 0;

      // slave error on write op 5
      prev = work_out;
      ev = rnd256(); wv = rnd256(); result = rnd256(); busy_polls = 1;
      err_addr = BASE + 32'h14;
      build_exp(ev, wv, result, 1, 5);
      d0 = done_cnt;
      run(ev, wv, -1, 2000, to);
      chk("t3_timeout", to, 1'b0);
      chk("t3_err", err_at_done, 1'b1);
      repeat (20) @(negedge pclk);
      cmp_log("t3");
      chk("t3_done_cnt", 256'(done_cnt - d0), 256'd1);
      chk("t3_work_out", work_out, prev);
      err_addr = 32'hFFFF_FFFF;

      // start pulsed mid-run is ignored
      ev = rnd256(); wv = rnd256(); result = rnd256(); busy_polls = 2;
      build_exp(ev, wv, result, 2, -1);
      d0 = done_cnt;
      run(ev, wv, 20, 2000, to);
      chk("t4_timeout", to, 1'b0);
      repeat (80) @(negedge pclk);
      cmp_log("t4");
      chk("t4_done_cnt", 256'(done_cnt - d0), 256'd1);
      chk("t4_work_out", work_out, result);

      // reset during op 10 access, then a fresh run
      d0 = done_cnt;
      @(negedge pclk);
      e = rnd256(); work_in = rnd256(); start = 1'b1;
      @(negedge pclk);
      start = 1'b0;
      to = 1'b1;
      for (int c = 0; c < 200; c++) begin
         if (apb_bus.psel && apb_bus.penable && apb_bus.paddr == BASE + 32'h68) begin
            to = 1'b0;
            break;
         end
         @(negedge pclk);
      end
      chk("t5_reach_op10", to, 1'b0);
      preset_n = 1'b0;
      @(negedge pclk);
      chk("t5_psel", {apb_bus.psel, apb_bus.penable}, 2'b00);
      chk("t5_busy", busy, 1'b0);
      preset_n = 1'b1;
      repeat (10) @(negedge pclk);
      chk("t5_no_done", 256'(done_cnt - d0), 256'd0);
      ev = rnd256(); wv = rnd256(); result = rnd256(); busy_polls = 0;
      build_exp(ev, wv, result, 0, -1);
      run(ev, wv, -1, 2000, to);
      chk("t5_timeout", to, 1'b0);
      cmp_log("t5");
      chk("t5_err", err_at_done, 1'b0);
      chk("t5_work_out", out_at_done, result);
      chk("t5_busy_cycles", 256'(busy_cycles), 256'(34 + 2 + 16 + 1));

`ifdef X25519_REQ_TIMEOUT_EN
      // status stuck busy: abort after TPOLLS polls
      prev = work_out;
      ev = rnd256(); wv = rnd256(); stuck = 1;
      build_exp(ev, wv, result, TPOLLS, 16 + TPOLLS);
      d0 = done_cnt;
      run(ev, wv, -1, 2000, to);
      chk("t6_timeout", to, 1'b0);
      cmp_log("t6");
      chk("t6_err", err_at_done, 1'b1);
      chk("t6_work_out", work_out, prev);
      stuck = 0;
`endif

      chk("bus_stability", 256'(stab_bad), 256'd0);
      chk("bus_strb_prot_wdata", 256'(sig_bad), 256'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
